// File: rtl/food_placer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// food_placer_pkg : grid constants, block codes and placer state encoding
// Revision        : 1.0
// ----------------------------------------------------------------------------
package food_placer_pkg;

  localparam int GRID_HEIGHT    = 30;
  localparam int GRID_WIDTH     = 40;
  localparam int BITS_PER_BLOCK = 2;

  localparam logic [BITS_PER_BLOCK-1:0] BLOCK_EMPTY = 2'd0;
  localparam logic [BITS_PER_BLOCK-1:0] BLOCK_WALL  = 2'd1;
  localparam logic [BITS_PER_BLOCK-1:0] BLOCK_SNAKE = 2'd2;
  localparam logic [BITS_PER_BLOCK-1:0] BLOCK_FOOD  = 2'd3;

  localparam int FP_STATE_BITS = 3;

  typedef enum logic [FP_STATE_BITS-1:0] {
    FP_IDLE       = 3'd0,
    FP_SAMPLE     = 3'd1,
    FP_WAIT       = 3'd2,
    FP_CHECK      = 3'd3,
    FP_SCAN       = 3'd4,
    FP_SCAN_WAIT  = 3'd5,
    FP_SCAN_CHECK = 3'd6
  } fp_state_e;

endpackage
`default_nettype wire

// File: rtl/food_placer_grid_cursor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// food_placer_grid_cursor : row-major (V,H) cell cursor with clear/advance/last
// Revision                : 1.0
// ----------------------------------------------------------------------------
module food_placer_grid_cursor
  import food_placer_pkg::*;
#(
  parameter int GRID_H = GRID_HEIGHT,
  parameter int GRID_W = GRID_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      advance,
  output logic [$clog2(GRID_H)-1:0] cur_v,
  output logic [$clog2(GRID_W)-1:0] cur_h,
  output logic                      last
);

  localparam int VW = $clog2(GRID_H);
  localparam int HW = $clog2(GRID_W);
  localparam logic [VW-1:0] V_LAST = VW'(GRID_H - 1);
  localparam logic [HW-1:0] H_LAST = HW'(GRID_W - 1);

  logic [VW-1:0] v_q, v_d;
  logic [HW-1:0] h_q, h_d;

  always_comb begin
    v_d = v_q;
    h_d = h_q;
    if (clear) begin
      v_d = '0;
      h_d = '0;
    end else if (advance) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      h_q <= '0;
    end else begin
      v_q <= v_d;
      h_q <= h_d;
    end
  end

  assign cur_v = v_q;
  assign cur_h = h_q;
  assign last  = (v_q == V_LAST) && (h_q == H_LAST);

endmodule
`default_nettype wire

// File: rtl/food_placer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// food_placer : validates randomizer candidates against the grid and writes one
//               food block per request; FOOD_PLACER_SCAN_FALLBACK_EN adds a scan
// Revision    : 1.0
// ----------------------------------------------------------------------------
module food_placer
  import food_placer_pkg::*;
#(
  parameter int GRID_H     = GRID_HEIGHT,
  parameter int GRID_W     = GRID_WIDTH,
  parameter int BLOCK_BITS = BITS_PER_BLOCK,
  parameter int MAX_TRIES  = 16
) (
  input  logic                      MasterClock,
  input  logic                      nReset,
  input  logic                      PlaceReq,
  input  logic [$clog2(GRID_H)-1:0] CandV,
  input  logic [$clog2(GRID_W)-1:0] CandH,
  output logic [$clog2(GRID_H)-1:0] RdV,
  output logic [$clog2(GRID_W)-1:0] RdH,
  input  logic [BLOCK_BITS-1:0]     RdData,
  output logic                      WrEn,
  output logic [$clog2(GRID_H)-1:0] WrV,
  output logic [$clog2(GRID_W)-1:0] WrH,
  output logic [BLOCK_BITS-1:0]     WrData,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Fail,
  output logic [$clog2(GRID_H)-1:0] FoodV,
  output logic [$clog2(GRID_W)-1:0] FoodH,
  output logic                      FoodValid
);

  localparam int VW = $clog2(GRID_H);
  localparam int HW = $clog2(GRID_W);
  localparam int TW = $clog2(MAX_TRIES + 1);

  localparam logic [VW:0]           V_LIMIT     = (VW + 1)'(GRID_H);
  localparam logic [HW:0]           H_LIMIT     = (HW + 1)'(GRID_W);
  localparam logic [TW-1:0]         TRIES_LIMIT = TW'(MAX_TRIES);
  localparam logic [BLOCK_BITS-1:0] EMPTY_CODE  = BLOCK_BITS'(BLOCK_EMPTY);
  localparam logic [BLOCK_BITS-1:0] FOOD_CODE   = BLOCK_BITS'(BLOCK_FOOD);

  fp_state_e     state_q, state_d;
  logic [VW-1:0] rd_v_q, rd_v_d, wr_v_q, wr_v_d, food_v_q, food_v_d;
  logic [HW-1:0] rd_h_q, rd_h_d, wr_h_q, wr_h_d, food_h_q, food_h_d;
  logic [TW-1:0] tries_q, tries_d;
  logic          wr_en_q, wr_en_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic          busy_q, busy_d;
  logic          food_valid_q, food_valid_d;

  logic [TW-1:0] tries_inc;
  logic          give_up;
  logic          cand_in_range;
  logic          rd_empty;

  assign cand_in_range = ({1'b0, CandV} < V_LIMIT) && ({1'b0, CandH} < H_LIMIT);
  assign rd_empty      = (RdData == EMPTY_CODE);

`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
  logic          cur_clear;
  logic          cur_advance;
  logic          cur_last;
  logic [VW-1:0] cur_v;
  logic [HW-1:0] cur_h;

  food_placer_grid_cursor #(
    .GRID_H (GRID_H),
    .GRID_W (GRID_W)
  ) u_grid_cursor (
    .clk     (MasterClock),
    .rst_n   (nReset),
    .clear   (cur_clear),
    .advance (cur_advance),
    .cur_v   (cur_v),
    .cur_h   (cur_h),
    .last    (cur_last)
  );
`endif

  always_comb begin
    state_d      = state_q;
    rd_v_d       = rd_v_q;
    rd_h_d       = rd_h_q;
    wr_v_d       = wr_v_q;
    wr_h_d       = wr_h_q;
    food_v_d     = food_v_q;
    food_h_d     = food_h_q;
    tries_d      = tries_q;
    food_valid_d = food_valid_q;
    wr_en_d      = 1'b0;
    done_d       = 1'b0;
    fail_d       = 1'b0;
    tries_inc    = tries_q + 1'b1;
    give_up      = 1'b0;
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
    cur_clear    = 1'b0;
    cur_advance  = 1'b0;
`endif

    case (state_q)
      FP_IDLE: begin
        if (PlaceReq) begin
          state_d = FP_SAMPLE;
          tries_d = '0;
        end
      end

      // Out-of-range candidates burn one try and one cycle without a read.
      FP_SAMPLE: begin
        if (cand_in_range) begin
          rd_v_d  = CandV;
          rd_h_d  = CandH;
          state_d = FP_WAIT;
        end else begin
          tries_d = tries_inc;
          give_up = (tries_inc == TRIES_LIMIT);
        end
      end

      FP_WAIT: state_d = FP_CHECK;

      FP_CHECK: begin
        if (rd_empty) begin
          wr_en_d      = 1'b1;
          done_d       = 1'b1;
          wr_v_d       = rd_v_q;
          wr_h_d       = rd_h_q;
          food_v_d     = rd_v_q;
          food_h_d     = rd_h_q;
          food_valid_d = 1'b1;
          state_d      = FP_IDLE;
        end else begin
          tries_d = tries_inc;
          state_d = FP_SAMPLE;
          give_up = (tries_inc == TRIES_LIMIT);
        end
      end

`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
      FP_SCAN: begin
        rd_v_d  = cur_v;
        rd_h_d  = cur_h;
        state_d = FP_SCAN_WAIT;
      end

      FP_SCAN_WAIT: state_d = FP_SCAN_CHECK;

      FP_SCAN_CHECK: begin
        if (rd_empty) begin
          wr_en_d      = 1'b1;
          done_d       = 1'b1;
          wr_v_d       = rd_v_q;
          wr_h_d       = rd_h_q;
          food_v_d     = rd_v_q;
          food_h_d     = rd_h_q;
          food_valid_d = 1'b1;
          state_d      = FP_IDLE;
        end else if (cur_last) begin
          fail_d       = 1'b1;
          food_valid_d = 1'b0;
          state_d      = FP_IDLE;
        end else begin
          cur_advance = 1'b1;
          state_d     = FP_SCAN;
        end
      end
`endif

      default: state_d = FP_IDLE;
    endcase

    if (give_up) begin
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
      state_d   = FP_SCAN;
      cur_clear = 1'b1;
`else
      state_d      = FP_IDLE;
      fail_d       = 1'b1;
      food_valid_d = 1'b0;
`endif
    end

    busy_d = (state_d != FP_IDLE);
  end

  always_ff @(posedge MasterClock or negedge nReset) begin
    if (!nReset) begin
      state_q      <= FP_IDLE;
      rd_v_q       <= '0;
      rd_h_q       <= '0;
      wr_v_q       <= '0;
      wr_h_q       <= '0;
      food_v_q     <= '0;
      food_h_q     <= '0;
      tries_q      <= '0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b0;
      food_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_v_q       <= rd_v_d;
      rd_h_q       <= rd_h_d;
      wr_v_q       <= wr_v_d;
      wr_h_q       <= wr_h_d;
      food_v_q     <= food_v_d;
      food_h_q     <= food_h_d;
      tries_q      <= tries_d;
      wr_en_q      <= wr_en_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
      food_valid_q <= food_valid_d;
    end
  end

  assign RdV       = rd_v_q;
  assign RdH       = rd_h_q;
  assign WrEn      = wr_en_q;
  assign WrV       = wr_v_q;
  assign WrH       = wr_h_q;
  assign WrData    = FOOD_CODE;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Fail      = fail_q;
  assign FoodV     = food_v_q;
  assign FoodH     = food_h_q;
  assign FoodValid = food_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_food_placer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_food_placer : randomized bench for food_placer with a grid RAM and a
//                  request-level reference model (honours FOOD_PLACER_SCAN_FALLBACK_EN)
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_food_placer;
  import food_placer_pkg::*;

  localparam int GH   = 6;
  localparam int GW   = 5;
  localparam int BB   = 2;
  localparam int MT   = 4;
  localparam int VW   = $clog2(GH);
  localparam int HW   = $clog2(GW);
  localparam int MAXC = 8000;

  logic          MasterClock = 1'b0;
  logic          nReset      = 1'b0;
  logic          PlaceReq    = 1'b0;
  logic [VW-1:0] CandV, RdV, WrV, FoodV;
  logic [HW-1:0] CandH, RdH, WrH, FoodH;
  logic [BB-1:0] RdData, WrData;
  logic          WrEn, Busy, Done, Fail, FoodValid;

  food_placer #(
    .GRID_H     (GH),
    .GRID_W     (GW),
    .BLOCK_BITS (BB),
    .MAX_TRIES  (MT)
  ) dut (
    .MasterClock (MasterClock),
    .nReset      (nReset),
    .PlaceReq    (PlaceReq),
    .CandV       (CandV),
    .CandH       (CandH),
    .RdV         (RdV),
    .RdH         (RdH),
    .RdData      (RdData),
    .WrEn        (WrEn),
    .WrV         (WrV),
    .WrH         (WrH),
    .WrData      (WrData),
    .Busy        (Busy),
    .Done        (Done),
    .Fail        (Fail),
    .FoodV       (FoodV),
    .FoodH       (FoodH),
    .FoodValid   (FoodValid)
  );

  always #5 MasterClock = ~MasterClock;

  // Grid RAM: a preloaded base layer plus food stamps from DUT writes since the last reload.
  int base_grid [0:7][0:7];
  int food_gen  [0:7][0:7];
  int grid_gen = 1;

  always @(posedge MasterClock) begin
    if (WrEn) food_gen[WrV][WrH] <= grid_gen;
    RdData <= (food_gen[RdV][RdH] == grid_gen) ? BLOCK_FOOD : BB'(base_grid[RdV][RdH]);
  end

  int cyc = 0;
  always @(posedge MasterClock) cyc <= cyc + 1;

  int cv [0:MAXC];
  int ch [0:MAXC];

  initial begin
    CandV = '0;
    CandH = '0;
    forever begin
      @(negedge MasterClock);
      CandV = VW'(cv[cyc+1]);
      CandH = HW'(ch[cyc+1]);
    end
  end

  int checks   = 0;
  int failures = 0;

  int exp_grid [0:7][0:7];
  bit exp_fv   = 1'b0;
  int exp_v    = 0;
  int exp_h    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_val);
    checks++;
    if (got !== exp_val) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t cyc=%0d)", tag, got, exp_val, $time, cyc);
    end
  endtask

  task automatic set_cell(input int v, input int h, input int val);
    base_grid[v][h] = val;
    exp_grid[v][h]  = val;
  endtask

  task automatic reload_grid(input int empty_pct);
    grid_gen++;
    for (int v = 0; v < GH; v++)
      for (int h = 0; h < GW; h++)
        set_cell(v, h, ($urandom_range(0, 99) < empty_pct) ? int'(BLOCK_EMPTY)
                                                           : int'($urandom_range(1, 3)));
  endtask

  // Request-level model: walks the candidate stream edge by edge and returns the
  // edge at which Done/Fail is registered, plus the placed cell.
  function automatic void predict(input int n, output int e_out, output bit wr,
                                  output int pv, output int ph);
    int t, tries, dec;
    t = n + 1; tries = 0; dec = t;
    wr = 1'b0; pv = 0; ph = 0; e_out = 0;
    while (tries < MT) begin
      if (cv[t] >= GH || ch[t] >= GW) begin
        tries++; dec = t; t += 1;
      end else if (exp_grid[cv[t]][ch[t]] == int'(BLOCK_EMPTY)) begin
        wr = 1'b1; pv = cv[t]; ph = ch[t]; e_out = t + 2;
        return;
      end else begin
        tries++; dec = t + 2; t += 3;
      end
    end
`ifdef FOOD_PLACER_SCAN_FALLBACK_EN
    for (int v = 0; v < GH; v++)
      for (int h = 0; h < GW; h++) begin
        if (exp_grid[v][h] == int'(BLOCK_EMPTY)) begin
          wr = 1'b1; pv = v; ph = h; e_out = t + 2;
          return;
        end
        dec = t + 2; t += 3;
      end
`endif
    e_out = dec;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_busy"}, Busy, 1'b0);
    check_eq({tag, "_wren"}, WrEn, 1'b0);
    check_eq({tag, "_done"}, Done, 1'b0);
    check_eq({tag, "_fail"}, Fail, 1'b0);
    check_eq({tag, "_fvalid"}, FoodValid, 1'b0);
    check_eq({tag, "_rdv"}, RdV, 0);
    check_eq({tag, "_rdh"}, RdH, 0);
    check_eq({tag, "_wrv"}, WrV, 0);
    check_eq({tag, "_wrh"}, WrH, 0);
    check_eq({tag, "_foodv"}, FoodV, 0);
    check_eq({tag, "_foodh"}, FoodH, 0);
  endtask

  // PlaceReq must already be high for edge cyc+1 when this is called.
  task automatic place(input bit noise, input bit hold);
    int n, e_end, pv, ph;
    bit wr;
    n = cyc + 1;
    predict(n, e_end, wr, pv, ph);
    for (int e = n; e <= e_end; e++) begin
      @(posedge MasterClock); #1;
      if (e == e_end) begin
        exp_fv = wr;
        if (wr) begin
          exp_v = pv;
          exp_h = ph;
        end
      end
      check_eq("busy", Busy, e < e_end);
      check_eq("wren", WrEn, wr && (e == e_end));
      check_eq("done", Done, wr && (e == e_end));
      check_eq("fail", Fail, !wr && (e == e_end));
      check_eq("food_valid", FoodValid, exp_fv);
      check_eq("food_v", FoodV, exp_v);
      check_eq("food_h", FoodH, exp_h);
      if (wr && e == e_end) begin
        check_eq("wr_v", WrV, pv);
        check_eq("wr_h", WrH, ph);
        check_eq("wr_data", WrData, BLOCK_FOOD);
      end
      if (e < e_end) PlaceReq = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      else           PlaceReq = hold;
    end
    if (wr) exp_grid[pv][ph] = int'(BLOCK_FOOD);
    if (!hold) begin
      @(posedge MasterClock); #1;
      check_eq("idle_busy", Busy, 1'b0);
      check_eq("idle_wren", WrEn, 1'b0);
      check_eq("idle_fail", Fail, 1'b0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int k, rv, rh;
    bit prev_hold;
    for (int i = 0; i <= MAXC; i++) begin
      cv[i] = $urandom_range(0, 7);
      ch[i] = $urandom_range(0, 7);
    end
    for (int v = 0; v < 8; v++)
      for (int h = 0; h < 8; h++) begin
        base_grid[v][h] = int'(BLOCK_EMPTY);
        exp_grid[v][h]  = int'(BLOCK_EMPTY);
        food_gen[v][h]  = 0;
      end

    repeat (3) @(negedge MasterClock);
    check_zero_outputs("reset");
    nReset = 1'b1;

    // Empty grid, first candidate accepted.
    @(negedge MasterClock);
    k = cyc; cv[k+2] = 2; ch[k+2] = 3;
    PlaceReq = 1'b1;
    place(1'b0, 1'b0);

    // SNAKE hit, out-of-range row, then an empty cell.
    set_cell(1, 1, int'(BLOCK_SNAKE));
    @(negedge MasterClock);
    k = cyc;
    cv[k+2] = 1; ch[k+2] = 1;
    cv[k+5] = 6; ch[k+5] = 0;
    cv[k+6] = 0; ch[k+6] = 2;
    PlaceReq = 1'b1;
    place(1'b1, 1'b0);

    // Only (3,3) free and never offered by the randomizer.
    grid_gen++;
    for (int v = 0; v < GH; v++)
      for (int h = 0; h < GW; h++)
        set_cell(v, h, (v == 3 && h == 3) ? int'(BLOCK_EMPTY) : int'($urandom_range(1, 3)));
    @(negedge MasterClock);
    k = cyc;
    for (int i = k + 1; i < k + 80; i++) begin
      do begin
        rv = $urandom_range(0, 7);
        rh = $urandom_range(0, 7);
      end while (rv == 3 && rh == 3);
      cv[i] = rv; ch[i] = rh;
    end
    PlaceReq = 1'b1;
    place(1'b0, 1'b0);

    // Fully occupied grid.
    reload_grid(0);
    @(negedge MasterClock);
    PlaceReq = 1'b1;
    place(1'b1, 1'b0);

    // Asynchronous reset while waiting on the read.
    reload_grid(100);
    @(negedge MasterClock);
    k = cyc; cv[k+2] = 1; ch[k+2] = 1;
    PlaceReq = 1'b1;
    @(posedge MasterClock); #1;
    PlaceReq = 1'b0;
    @(posedge MasterClock); #1;
    check_eq("pre_reset_busy", Busy, 1'b1);
    nReset = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    exp_fv = 1'b0; exp_v = 0; exp_h = 0;
    @(negedge MasterClock);
    nReset = 1'b1;
    @(posedge MasterClock); #1;
    check_eq("post_reset_wren", WrEn, 1'b0);
    check_eq("post_reset_busy", Busy, 1'b0);
    @(negedge MasterClock);
    k = cyc; cv[k+2] = 4; ch[k+2] = 1;
    PlaceReq = 1'b1;
    place(1'b0, 1'b0);

    // Randomized traffic, including held PlaceReq and noise while busy.
    prev_hold = 1'b0;
    for (int r = 0; r < 40; r++) begin
      bit hold;
      if (!prev_hold && (r % 4 == 0)) reload_grid((r % 12 == 0) ? 15 : 45);
      hold = (r != 39) && ($urandom_range(0, 2) != 0);
      if (!PlaceReq) begin
        @(negedge MasterClock);
        PlaceReq = 1'b1;
      end
      place(1'($urandom_range(0, 1)), hold);
      prev_hold = hold;
    end

    PlaceReq = 1'b0;
    repeat (2) @(posedge MasterClock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
